ps2_scan_decoder: RTL
=====================

Name: ps2_scan_decoder

Overview:
- Consumes the 8-bit scan-code bytes and the one-cycle valid tick from the PS/2 receive stage.
- Parses Set-2 prefixes: E0 marks an extended key, F0 marks a key release, and E1 starts the 8-byte Pause sequence.
- Emits complete key events (code, extended, break) into a small first-word-fall-through event FIFO drained by the application.
- Tracks whether either Shift key is held.

Parameters:
- FIFO_DEPTH, 4, number of event entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 2000000, idle clocks allowed after a prefix byte before the parser abandons the sequence (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- code  in  8  scan-code byte from the receive stage; sampled only when code_tick=1.
- code_tick  in  1  one-cycle strobe marking a new byte on code.
- rd_en  in  1  pop the head event; ignored while ev_valid=0.
- ev_code  out  8  head event key code (prefixes stripped).
- ev_ext  out  1  head event was E0-prefixed.
- ev_break  out  1  head event is a release (1) or a press (0).
- ev_valid  out  1  FIFO not empty.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- shift_held  out  1  left Shift (0x12) or right Shift (0x59), non-extended, currently pressed.

Behaviour:
- Reset (rst=0, async) forces: FSM=IDLE, FIFO empty, ev_valid=0, ev_code=8'h00, ev_ext=0, ev_break=0, overflow=0, shift_held=0, timeout counter=0, pause counter=0. Reset mid-sequence discards any partial sequence.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions occur only on code_tick, except timeout.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, with pause counter loaded to 7.
  - 00, AA, FA, FC, FE, FF -> dropped, stay in IDLE.
  - Any other byte -> push {code, ext=0, brk=0}.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay in EXT.
  - Any other byte -> push {code, 1, 0}, go to IDLE.
  - The fake-shift byte 12 after E0 is pushed as an ordinary extended event.
- BRK: any byte -> push {code, 0, 1}, go to IDLE.
- EXT_BRK: any byte -> push {code, 1, 1}, go to IDLE.
- PAUSE:
  - Each tick decrements the pause counter.
  - When the counter reaches 0 after the 7th byte, push {8'hE1, 0, 0} once and go to IDLE.
  - Byte values inside the Pause sequence are not interpreted.
- Timeout:
  - The counter is cleared on every code_tick and in IDLE, and increments each clock in any other state.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE with no event and the counter clears.
- Latency: a code_tick at cycle N that completes an event makes it visible with ev_valid=1 and the ev_* fields valid at cycle N+1.
- FIFO:
  - The head is presented combinationally from the storage array (first-word fall-through).
  - rd_en with ev_valid=1 advances the head at the next edge.
  - Pointers are log2(FIFO_DEPTH) bits and wrap, plus a count of log2(FIFO_DEPTH)+1 bits.
  - Push while full and no pop: the event is dropped, overflow is set to 1, and overflow holds until reset.
  - Push and pop in the same cycle: both are performed, count unchanged, with no overflow even when full.
  - Pop while empty: no effect.
- shift_held:
  - Updated at the same edge as the push for a non-extended 12/59 event: make sets the per-side bit, break clears it.
  - Updated even if that push is dropped for overflow.
  - Output is the OR of the two side bits. Extended 12 (fake shift) does not affect it.

Decomposition:
- Shared package ps2_pkg holds:
  - state enum type ps2_dec_state_t.
  - Constants PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_PFX_PAUSE=8'hE1, PS2_LSHIFT=8'h12, PS2_RSHIFT=8'h59.
  - The list of dropped response bytes.
  - Packed struct ps2_key_ev_t {code[7:0], ext, brk}.
- One natural sub-module, ps2_event_fifo: parameterised FWFT FIFO with push/pop/full/empty and async active-low reset. The FSM, timeout counter and shift tracking stay in the top.

Test Plan:
- 1C single tick -> next cycle ev_valid=1, ev_code=1C, ev_ext=0, ev_break=0; rd_en one cycle -> ev_valid=0.
- E0,F0,74 ticks -> exactly one event {74,1,1}; E0,75 -> {75,1,0}.
- 12, then 59, then F0,12 -> shift_held goes 1 after 12 and stays 1 until F0,59 -> 0; E0,12 leaves shift_held unchanged.
- Five key bytes with no rd_en, FIFO_DEPTH=4 -> first four retained in order, fifth dropped, overflow=1; push+pop same cycle while full -> count stays 4, overflow unchanged.
- E0 then silence for TIMEOUT_CYCLES (override to 16) -> FSM back in IDLE; following 1C -> event {1C,0,0}, not extended.
- E1,14,77,E1,F0,14,F0,77 -> single event {E1,0,0}; FA and AA bytes -> no events. Assert rst=0 mid E0,F0 -> all outputs reset, next 1C -> {1C,0,0}.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scan-code decoder.
// Holds the parser state enum, prefix/shift codes and the key-event bundle.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } ps2_dec_state_t;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_LSHIFT    = 8'h12;
    localparam logic [7:0] PS2_RSHIFT    = 8'h59;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_key_ev_t;

    // Keyboard response bytes (error, BAT, ack, resend...) never form a key.
    function automatic logic ps2_is_resp(input logic [7:0] b);
        logic r;
        case (b)
            8'h00, 8'hAA, 8'hFA,
            8'hFC, 8'hFE, 8'hFF: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO of decoded key events with sticky overflow.
// Ports: push/din write, pop/dout read head, full/empty flags, overflow.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  ps2_key_ev_t din,
    input  logic        pop,
    output ps2_key_ev_t dout,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);

    ps2_key_ev_t     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_pop;
    logic            do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    // Empty head reads as zero so the outputs are clean after reset.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 scan-code parser: strips E0/F0/E1 prefixes into key events.
// Ports: code/code_tick in, rd_en pop, ev_* head event, overflow, shift_held.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code,
    input  logic       code_tick,
    input  logic       rd_en,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_valid,
    output logic       overflow,
    output logic       shift_held
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    ps2_dec_state_t state, state_n;
    logic [2:0]     pause_cnt, pause_n;
    logic [TW-1:0]  tmo_cnt, tmo_n;
    logic           lshift, lshift_n;
    logic           rshift, rshift_n;
    logic           push;
    ps2_key_ev_t    ev_in;
    ps2_key_ev_t    head;
    logic           fifo_full;
    logic           fifo_empty;

    always_comb begin
        state_n = state;
        pause_n = pause_cnt;
        tmo_n   = tmo_cnt;
        push    = 1'b0;
        ev_in   = '0;
        if (code_tick) begin
            tmo_n = '0;
            case (state)
                ST_IDLE: begin
                    if (code == PS2_PFX_EXT) begin
                        state_n = ST_EXT;
                    end else if (code == PS2_PFX_BRK) begin
                        state_n = ST_BRK;
                    end else if (code == PS2_PFX_PAUSE) begin
                        state_n = ST_PAUSE;
                        pause_n = 3'd7;
                    end else if (!ps2_is_resp(code)) begin
                        push  = 1'b1;
                        ev_in = '{code, 1'b0, 1'b0};
                    end
                end
                ST_EXT: begin
                    if (code == PS2_PFX_BRK) begin
                        state_n = ST_EXT_BRK;
                    end else if (code != PS2_PFX_EXT) begin
                        push    = 1'b1;
                        ev_in   = '{code, 1'b1, 1'b0};
                        state_n = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    push    = 1'b1;
                    ev_in   = '{code, 1'b0, 1'b1};
                    state_n = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    push    = 1'b1;
                    ev_in   = '{code, 1'b1, 1'b1};
                    state_n = ST_IDLE;
                end
                ST_PAUSE: begin
                    // Payload bytes are counted, never decoded.
                    pause_n = pause_cnt - 3'd1;
                    if (pause_cnt == 3'd1) begin
                        push    = 1'b1;
                        ev_in   = '{PS2_PFX_PAUSE, 1'b0, 1'b0};
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state_n = ST_IDLE;
                tmo_n   = '0;
            end else begin
                tmo_n = tmo_cnt + 1'b1;
            end
        end else begin
            tmo_n = '0;
        end
    end

    // Shift state follows the parsed event, even if the FIFO drops it.
    always_comb begin
        lshift_n = lshift;
        rshift_n = rshift;
        if (push && !ev_in.ext) begin
            if (ev_in.code == PS2_LSHIFT) begin
                lshift_n = !ev_in.brk;
            end
            if (ev_in.code == PS2_RSHIFT) begin
                rshift_n = !ev_in.brk;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pause_cnt <= '0;
            tmo_cnt   <= '0;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
        end else begin
            state     <= state_n;
            pause_cnt <= pause_n;
            tmo_cnt   <= tmo_n;
            lshift    <= lshift_n;
            rshift    <= rshift_n;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (push),
        .din      (ev_in),
        .pop      (rd_en),
        .dout     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign ev_code    = head.code;
    assign ev_ext     = head.ext;
    assign ev_break   = head.brk;
    assign ev_valid   = !fifo_empty;
    assign shift_held = lshift || rshift;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
